// File: rtl/cross_bar_pkg.sv
// Shared types and constants for the crossbar: master/slave numbering and
// the address-to-slave decode used by the arbiter.
package cross_bar_pkg;
    localparam int MASTER_N    = 4;
    localparam int SLAVE_N     = 4;
    localparam int ADDR_W      = 32;
    localparam int SLAVE_SEL_W = $clog2(SLAVE_N);
    localparam int MNUM_W      = $clog2(MASTER_N + 1);
    localparam int SNUM_W      = $clog2(SLAVE_N + 1);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [MNUM_W-1:0] master_num_t;
    typedef logic [SNUM_W-1:0] slave_num_t;

    typedef enum logic { SLV_FREE = 1'b0, SLV_BUSY = 1'b1 } slv_state_e;

    // Slave numbers are 1-based so that 0 can mean "no slave".
    function automatic slave_num_t addr2slave(addr_t addr);
        return slave_num_t'(addr[ADDR_W-1 -: SLAVE_SEL_W]) + slave_num_t'(1);
    endfunction
endpackage

// File: rtl/cross_bar_arbiter_if.sv
// Request/grant bundle between the masters' front end and the crossbar arbiter.
interface cross_bar_arbiter_if;
    import cross_bar_pkg::*;

    logic        [MASTER_N:1] master_req;
    addr_t       [MASTER_N:1] master_addr;
    logic        [SLAVE_N:1]  slave_ack;
    master_num_t [SLAVE_N:1]  slave_mux;
    slave_num_t  [MASTER_N:1] master_mux;

    modport master (output master_req, master_addr, slave_ack,
                    input  slave_mux, master_mux);
    modport slave  (input  master_req, master_addr, slave_ack,
                    output slave_mux, master_mux);
endinterface

// File: rtl/cross_bar_rr_arb.sv
// MASTER_N-way round-robin pick: searches upward from the master after `last`,
// wrapping MASTER_N -> 1. Emits a one-hot grant and the encoded winner (0 = none).
module cross_bar_rr_arb
    import cross_bar_pkg::*;
(
    input  logic [MASTER_N:1] req,
    input  master_num_t       last,
    output logic [MASTER_N:1] gnt,
    output master_num_t       winner
);
    always_comb begin
        int idx;
        gnt    = '0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= MASTER_N; k++) begin
            idx = ((int'(last) + k - 1) % MASTER_N) + 1;
            if (winner == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = master_num_t'(idx);
            end
        end
    end
endmodule

// File: rtl/cross_bar_arbiter.sv
// Crossbar mux controller: decodes each master's target slave and runs one
// round-robin arbiter per slave, holding each grant until ack or abort.
module cross_bar_arbiter
    import cross_bar_pkg::*;
(
    input  logic                clk,
    input  logic                aresetn,
    cross_bar_arbiter_if.slave  bus
);
    slv_state_e  [SLAVE_N:1]              st;
    master_num_t [SLAVE_N:1]              owner;
    master_num_t [SLAVE_N:1]              last;
    logic        [MASTER_N:1]             owns;
    slave_num_t  [MASTER_N:1]             mmux;
    logic        [SLAVE_N:1][MASTER_N:1]  cand;
    logic        [SLAVE_N:1][MASTER_N:1]  gnt;
    master_num_t [SLAVE_N:1]              win;

    // Ownership view per master, built from the owner registers only.
    always_comb begin
        mmux = '0;
        owns = '0;
        for (int s = 1; s <= SLAVE_N; s++)
            for (int m = 1; m <= MASTER_N; m++)
                if (owner[s] == master_num_t'(m)) begin
                    mmux[m] = slave_num_t'(s);
                    owns[m] = 1'b1;
                end
    end

    // A master already holding a slave never competes, which also drops the
    // current owner from same-edge re-arbitration on ack.
    always_comb begin
        cand = '0;
        for (int s = 1; s <= SLAVE_N; s++)
            for (int m = 1; m <= MASTER_N; m++)
                cand[s][m] = bus.master_req[m] && !owns[m] &&
                             (addr2slave(bus.master_addr[m]) == slave_num_t'(s));
    end

    for (genvar s = 1; s <= SLAVE_N; s++) begin : g_slv
        cross_bar_rr_arb u_arb (
            .req    (cand[s]),
            .last   (last[s]),
            .gnt    (gnt[s]),
            .winner (win[s])
        );
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                st[s]    <= SLV_FREE;
                owner[s] <= '0;
                last[s]  <= master_num_t'(MASTER_N);
            end
        end else begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                case (st[s])
                    SLV_FREE: begin
                        if (|gnt[s]) begin
                            st[s]    <= SLV_BUSY;
                            owner[s] <= win[s];
                            last[s]  <= win[s];
                        end
                    end
                    SLV_BUSY: begin
                        if (bus.slave_ack[s]) begin
                            if (|gnt[s]) begin
                                owner[s] <= win[s];
                                last[s]  <= win[s];
                            end else begin
                                st[s]    <= SLV_FREE;
                                owner[s] <= '0;
                            end
                        end else if (!bus.master_req[owner[s]]) begin
                            st[s]    <= SLV_FREE;
                            owner[s] <= '0;
                        end
                    end
                    default: begin
                        st[s]    <= SLV_FREE;
                        owner[s] <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.slave_mux  = owner;
    assign bus.master_mux = mmux;
endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed bench for cross_bar_arbiter: expected mux snapshots are queued as
// stimulus is applied and compared one cycle later.
module tb_cross_bar_arbiter;
    import cross_bar_pkg::*;

    logic clk;
    logic aresetn;
    int   ncmp;
    int   nerr;
    logic [23:0] exp_q[$];

    cross_bar_arbiter_if bus();

    cross_bar_arbiter dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pk(int a4, int a3, int a2, int a1);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1)};
    endfunction

    function automatic addr_t tgt(int s);
        addr_t a;
        a = addr_t'($urandom());
        a[31:30] = 2'(s - 1);
        return a;
    endfunction

    task automatic drv(int m, int s);
        bus.master_req[m]  = 1'b1;
        bus.master_addr[m] = tgt(s);
    endtask

    task automatic check(input string tag);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        ncmp++;
        assert (bus.slave_mux === e[23:12]) else begin
            nerr++;
            $error("FAIL %s slave_mux observed=%h expected=%h", tag, bus.slave_mux, e[23:12]);
        end
        ncmp++;
        assert (bus.master_mux === e[11:0]) else begin
            nerr++;
            $error("FAIL %s master_mux observed=%h expected=%h", tag, bus.master_mux, e[11:0]);
        end
    endtask

    task automatic step(input string tag, input logic [11:0] es, input logic [11:0] em);
        exp_q.push_back({es, em});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        aresetn = 1'b0;
        bus.slave_ack = '0;
        bus.master_req = 4'($urandom());
        for (int m = 1; m <= 4; m++) bus.master_addr[m] = addr_t'($urandom());

        // Reset holds everything idle regardless of inputs
        step("rst_a", pk(0,0,0,0), pk(0,0,0,0));
        bus.master_req = 4'($urandom()) | 4'b0001;
        bus.slave_ack  = 4'($urandom());
        for (int m = 1; m <= 4; m++) bus.master_addr[m] = addr_t'($urandom());
        step("rst_b", pk(0,0,0,0), pk(0,0,0,0));

        bus.master_req = '0;
        bus.slave_ack  = '0;
        aresetn = 1'b1;
        step("rel_idle", pk(0,0,0,0), pk(0,0,0,0));

        // Round robin on S1: first contention goes to M1, then 2,3,4,1 with no bubble
        for (int m = 1; m <= 4; m++) drv(m, 1);
        step("rr_g1", pk(0,0,0,1), pk(0,0,0,1));
        bus.slave_ack[1] = 1'b1;
        step("rr_g2", pk(0,0,0,2), pk(0,0,1,0));
        step("rr_g3", pk(0,0,0,3), pk(0,1,0,0));
        step("rr_g4", pk(0,0,0,4), pk(1,0,0,0));
        step("rr_g1b", pk(0,0,0,1), pk(0,0,0,1));
        bus.slave_ack = '0;
        bus.master_req = '0;
        step("rr_abort", pk(0,0,0,0), pk(0,0,0,0));

        // Single transfer M2 -> S2, ack on the third granted cycle
        drv(2, 2);
        bus.master_addr[2] = 32'h4000_0000;
        step("single_n1", pk(0,0,2,0), pk(0,0,2,0));
        step("single_n2", pk(0,0,2,0), pk(0,0,2,0));
        step("single_n3", pk(0,0,2,0), pk(0,0,2,0));
        bus.slave_ack[2]  = 1'b1;
        bus.master_req[2] = 1'b0;
        step("single_ack", pk(0,0,0,0), pk(0,0,0,0));
        bus.slave_ack = '0;

        // Parallel grants: M1..M4 -> S4..S1
        drv(1, 4); drv(2, 3); drv(3, 2); drv(4, 1);
        step("par_grant", pk(1,2,3,4), pk(1,2,3,4));
        bus.master_req = '0;
        step("par_abort", pk(0,0,0,0), pk(0,0,0,0));

        // Abort: last[1]=4 so M3 beats M4, M3 drops, M4 follows after a free cycle
        drv(3, 1); drv(4, 1);
        step("abort_g3", pk(0,0,0,3), pk(0,1,0,0));
        bus.master_req[3] = 1'b0;
        step("abort_drop", pk(0,0,0,0), pk(0,0,0,0));
        step("abort_g4", pk(0,0,0,4), pk(1,0,0,0));
        bus.master_req = '0;
        step("abort_end", pk(0,0,0,0), pk(0,0,0,0));

        // Sole requester back-to-back, plus stray ack on a free slave
        drv(1, 2);
        step("sole_g1", pk(0,0,1,0), pk(0,0,0,2));
        bus.slave_ack[2] = 1'b1;
        step("sole_bubble", pk(0,0,0,0), pk(0,0,0,0));
        bus.slave_ack = '0;
        step("sole_g2", pk(0,0,1,0), pk(0,0,0,2));
        bus.slave_ack[3] = 1'b1;
        step("stray_ack", pk(0,0,1,0), pk(0,0,0,2));
        bus.slave_ack = 4'b0010;
        bus.master_req = '0;
        step("sole_done", pk(0,0,0,0), pk(0,0,0,0));
        bus.slave_ack = '0;

        // Live decode before grant: M1 waits on busy S3, then retargets to S4
        drv(2, 3);
        step("rt_m2", pk(0,2,0,0), pk(0,0,3,0));
        drv(1, 3);
        step("rt_wait", pk(0,2,0,0), pk(0,0,3,0));
        bus.master_addr[1] = tgt(4);
        step("rt_move", pk(1,2,0,0), pk(0,0,3,4));
        bus.master_req = '0;
        step("rt_end", pk(0,0,0,0), pk(0,0,0,0));

        // Async reset mid-transfer drops the grant without a clock edge
        drv(1, 1);
        step("ar_grant", pk(0,0,0,1), pk(0,0,0,1));
        #2;
        exp_q.push_back({pk(0,0,0,0), pk(0,0,0,0)});
        aresetn = 1'b0;
        #1;
        check("ar_async");
        bus.master_req = '0;
        @(negedge clk);
        aresetn = 1'b1;
        step("ar_rel", pk(0,0,0,0), pk(0,0,0,0));

        // Round-robin pointer is restored: M1 first again on S2
        for (int m = 1; m <= 4; m++) drv(m, 2);
        step("ar_prio", pk(0,0,1,0), pk(0,0,0,2));
        bus.master_req = '0;
        step("final_idle", pk(0,0,0,0), pk(0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
